// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronized rows, and debounces whole-sweep results before committing a key.
module keypad_scan #(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_SWEEPS = 10
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       is_pressed,
   output logic [3:0] key_data,
   output logic       key_pulse
);

   localparam int              DW       = $clog2(SCAN_DIV);
   localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0]      DB       = 4'(DEBOUNCE_SWEEPS);

   typedef enum logic {SCAN, EVAL} state_t;

   state_t        state_q, state_d;
   logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]    col_q, col_d;
   logic [DW-1:0] div_q, div_d;
   logic [15:0]   samp_q, samp_d;       // active-low, bit index col*4+row
   logic          cand_vld_q, cand_vld_d;
   logic [3:0]    cand_code_q, cand_code_d;
   logic [3:0]    match_q, match_d;
   logic [3:0]    col_n_q, col_n_d;
   logic          pressed_q, pressed_d;
   logic [3:0]    key_q, key_d;
   logic          pulse_q, pulse_d;

   logic [4:0]    n_low;
   logic [3:0]    low_idx;
   logic          res_vld;
   logic [3:0]    res_code;
   logic [1:0]    col_nxt;

   // Keypad legend indexed by {row, col}.
   function automatic logic [3:0] key_code(input logic [3:0] rc);
      case (rc)
         4'b0000: key_code = 4'h1;  4'b0001: key_code = 4'h2;
         4'b0010: key_code = 4'h3;  4'b0011: key_code = 4'hA;
         4'b0100: key_code = 4'h4;  4'b0101: key_code = 4'h5;
         4'b0110: key_code = 4'h6;  4'b0111: key_code = 4'hB;
         4'b1000: key_code = 4'h7;  4'b1001: key_code = 4'h8;
         4'b1010: key_code = 4'h9;  4'b1011: key_code = 4'hC;
         4'b1100: key_code = 4'hE;  4'b1101: key_code = 4'h0;
         4'b1110: key_code = 4'hF;  default: key_code = 4'hD;
      endcase
   endfunction

   // Sweep result: exactly one low bit is a key; zero or several are "none"
   // (none carries code 0 so that repeated none sweeps compare equal).
   always_comb begin
      n_low   = '0;
      low_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (!samp_q[i]) begin
            n_low   = n_low + 5'd1;
            low_idx = 4'(i);
         end
      end
      res_vld  = (n_low == 5'd1);
      res_code = res_vld ? key_code({low_idx[1:0], low_idx[3:2]}) : 4'h0;
   end

   // Scan sequencing, debounce and commit logic.
   always_comb begin
      state_d     = state_q;
      sync1_d     = row_n;
      sync2_d     = sync1_q;
      col_d       = col_q;
      div_d       = div_q;
      samp_d      = samp_q;
      cand_vld_d  = cand_vld_q;
      cand_code_d = cand_code_q;
      match_d     = match_q;
      col_n_d     = col_n_q;
      pressed_d   = pressed_q;
      key_d       = key_q;
      pulse_d     = 1'b0;
      col_nxt     = col_q + 2'd1;
      case (state_q)
         SCAN: begin
            if (div_q == DIV_LAST) begin
               samp_d[{col_q, 2'b00} +: 4] = sync2_q;
               div_d = '0;
               if (col_q == 2'd3) begin
                  state_d = EVAL;
                  col_n_d = 4'b1111;
               end else begin
                  col_d   = col_nxt;
                  col_n_d = ~(4'b0001 << col_nxt);
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = SCAN;
            col_d   = 2'd0;
            div_d   = '0;
            col_n_d = 4'b1110;
            if ({res_vld, res_code} == {cand_vld_q, cand_code_q}) begin
               match_d = (match_q == DB) ? DB : match_q + 4'd1;
            end else begin
               cand_vld_d  = res_vld;
               cand_code_d = res_code;
               match_d     = 4'd1;
            end
            // Commit lands on the edge closing EVAL; a recommit of the
            // same state leaves every output untouched.
            if (match_d == DB) begin
               if (cand_vld_d) begin
                  pressed_d = 1'b1;
                  key_d     = cand_code_d;
                  pulse_d   = !pressed_q || (key_q != cand_code_d);
               end else begin
                  pressed_d = 1'b0;
               end
            end
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= SCAN;
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         col_q       <= 2'd0;
         div_q       <= '0;
         samp_q      <= 16'hFFFF;
         cand_vld_q  <= 1'b0;
         cand_code_q <= 4'h0;
         match_q     <= 4'd0;
         col_n_q     <= 4'b1110;
         pressed_q   <= 1'b0;
         key_q       <= 4'h0;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         col_q       <= col_d;
         div_q       <= div_d;
         samp_q      <= samp_d;
         cand_vld_q  <= cand_vld_d;
         cand_code_q <= cand_code_d;
         match_q     <= match_d;
         col_n_q     <= col_n_d;
         pressed_q   <= pressed_d;
         key_q       <= key_d;
         pulse_q     <= pulse_d;
      end
   end

   assign col_n      = col_n_q;
   assign is_pressed = pressed_q;
   assign key_data   = key_q;
   assign key_pulse  = pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SWEEPS=3 (17-clock sweep).
// A behavioral key matrix pulls rows low when the pressed key's column is driven.
module tb_keypad_scan;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        is_pressed;
   logic [3:0]  key_data;
   logic        key_pulse;

   logic [15:0] keys;      // bit r*4+c set = key at row r / column c held
   int          k;         // falling edges since last reset release
   int          pulses;    // key_pulse cycles seen
   int          lows;      // cycles with is_pressed low, cleared on demand
   int          n_chk;
   int          n_bad;
   logic [3:0]  col_tab [5];

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SWEEPS(3)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .row_n      (row_n),
      .col_n      (col_n),
      .is_pressed (is_pressed),
      .key_data   (key_data),
      .key_pulse  (key_pulse)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Passive keypad: a held key shorts its row to the driven column.
   always_comb begin
      row_n = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
      end
   endtask

   task automatic adv_to(input int t);
      while (k < t) begin
         @(negedge sys_clk);
         k++;
         if (key_pulse) pulses++;
         if (!is_pressed) lows++;
      end
   endtask

   function automatic int kb(input int r, input int c);
      return r*4 + c;
   endfunction

   initial begin
      n_chk = 0; n_bad = 0; pulses = 0; lows = 0; k = 0;
      keys = 16'h0;
      col_tab[0] = 4'b1110; col_tab[1] = 4'b1101; col_tab[2] = 4'b1011;
      col_tab[3] = 4'b0111; col_tab[4] = 4'b1111;
      sys_rst_n = 1'b1;
      #3 sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_col_n",   16'(col_n),      16'hE);
      chk("rst_pressed", 16'(is_pressed), 16'h0);
      chk("rst_key",     16'(key_data),   16'h0);
      chk("rst_pulse",   16'(key_pulse),  16'h0);
      sys_rst_n = 1'b1;
      k = 0;

      // Idle scan pattern over one sweep.
      for (int i = 0; i <= 16; i++) begin
         adv_to(i);
         chk($sformatf("col_seq%0d", i), 16'(col_n), 16'(col_tab[i/4]));
      end
      adv_to(17);
      chk("col_wrap", 16'(col_n), 16'hE);

      // Key 5 (r1/c1) pressed at start of sweep 3; commit after sweep 5.
      adv_to(51);
      chk("idle_pressed", 16'(is_pressed), 16'h0);
      keys = 16'h0; keys[kb(1,1)] = 1'b1;
      adv_to(101);
      chk("k5_early",     16'(is_pressed), 16'h0);
      chk("idle_pulses",  16'(pulses),     16'h0);
      adv_to(102);
      chk("k5_pressed",   16'(is_pressed), 16'h1);
      chk("k5_data",      16'(key_data),   16'h5);
      chk("k5_pulse",     16'(key_pulse),  16'h1);
      keys = 16'h0;
      adv_to(103);
      chk("k5_pulse_1clk", 16'(key_pulse), 16'h0);
      adv_to(152);
      chk("rel_hold",     16'(is_pressed), 16'h1);
      adv_to(153);
      chk("rel_pressed",  16'(is_pressed), 16'h0);
      chk("rel_data",     16'(key_data),   16'h5);
      chk("rel_pulses",   16'(pulses),     16'h1);

      // Key D (r3/c3) held for two sweeps only: rejected as bounce.
      keys[kb(3,3)] = 1'b1;
      adv_to(187);
      keys = 16'h0;
      lows = 0;
      adv_to(238);
      chk("bounce_pressed", 16'(lows),     16'd51);
      chk("bounce_data",  16'(key_data),   16'h5);
      chk("bounce_pulses", 16'(pulses),    16'h1);

      // Two keys together: treated as none.
      keys[kb(0,0)] = 1'b1; keys[kb(2,1)] = 1'b1;
      lows = 0;
      adv_to(306);
      chk("multi_lows",   16'(lows),       16'd68);
      chk("multi_data",   16'(key_data),   16'h5);
      chk("multi_pulses", 16'(pulses),     16'h1);

      // Key A then direct switch to key 1.
      keys = 16'h0; keys[kb(0,3)] = 1'b1;
      adv_to(357);
      chk("ka_pressed",   16'(is_pressed), 16'h1);
      chk("ka_data",      16'(key_data),   16'hA);
      chk("ka_pulse",     16'(key_pulse),  16'h1);
      keys = 16'h0; keys[kb(0,0)] = 1'b1;
      lows = 0;
      adv_to(407);
      chk("k1_early",     16'(key_data),   16'hA);
      adv_to(408);
      chk("k1_data",      16'(key_data),   16'h1);
      chk("k1_pulse",     16'(key_pulse),  16'h1);
      chk("k1_no_drop",   16'(lows),       16'h0);
      chk("k1_pulses",    16'(pulses),     16'h3);

      // Key 7 committed, then asynchronous reset mid-sweep.
      keys = 16'h0; keys[kb(2,0)] = 1'b1;
      adv_to(459);
      chk("k7_data",      16'(key_data),   16'h7);
      chk("k7_pulses",    16'(pulses),     16'h4);
      adv_to(465);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_col_n",   16'(col_n),      16'hE);
      chk("arst_pressed", 16'(is_pressed), 16'h0);
      chk("arst_key",     16'(key_data),   16'h0);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      k = 0;
      pulses = 0;
      adv_to(50);
      chk("k7_re_early",  16'(is_pressed), 16'h0);
      chk("k7_re_nopulse", 16'(pulses),    16'h0);
      adv_to(51);
      chk("k7_re_pressed", 16'(is_pressed), 16'h1);
      chk("k7_re_data",   16'(key_data),   16'h7);
      chk("k7_re_pulse",  16'(key_pulse),  16'h1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, sets clocks per column drive period (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 Parameter DEBOUNCE_SWEEPS, default 10, sets consecutive identical sweeps needed to commit a key state; legal range 1..15.
REQ-003 Port sys_clk  input  1  system clock, 100 MHz.
REQ-004 Port sys_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to sys_clk.
REQ-006 Port col_n  output  4  keypad column drive, one-hot active-low.
REQ-007 Port is_pressed  output  1  debounced "exactly one key held" level, consumed as the downstream press flag.
REQ-008 Port key_data  output  4  code of the last committed pressed key, held after release.
REQ-009 Port key_pulse  output  1  single-cycle strobe on each newly committed press.

Function
REQ-010 The block SHALL pass row_n through a 2-flop synchronizer; only synchronized rows are used.
REQ-011 A divider counter SHALL count 0..SCAN_DIV-1 per column; column index SHALL advance 0->1->2->3 at each terminal count.
REQ-012 col_n SHALL drive low only bit[col index]; all other bits high.
REQ-013 Synchronized rows SHALL be sampled on the terminal-count cycle of each column, before the column advances.
REQ-014 States: SCAN (columns 0..3 driven, sampling) and EVAL (one cycle, col_n held at 4'b1111). After column 3 samples, the state SHALL go SCAN->EVAL; EVAL SHALL go ->SCAN with column 0 and divider 0. Sweep period is 4*SCAN_DIV+1 clocks.
REQ-015 Sweep result SHALL be: "single key" if exactly one of the 16 row/column bits is low; "none" if zero or two or more are low (ghosting/multi-press is rejected as none).
REQ-016 Key code map, row r / column c: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D. This matches the downstream decoder: 1..7 notes, A..C scale select.
REQ-017 In EVAL the block SHALL compare the result {valid,code} with the candidate. If equal, a match counter SHALL increment, saturating at DEBOUNCE_SWEEPS. If different, the candidate SHALL load the result and the counter SHALL load 1.
REQ-018 When the match counter equals DEBOUNCE_SWEEPS in EVAL, the candidate SHALL be committed on the next clock.
REQ-019 Commit of a valid code SHALL set is_pressed=1 and key_data=code. Commit of none SHALL set is_pressed=0 and leave key_data unchanged.
REQ-020 key_pulse SHALL assert for exactly one clock, coincident with is_pressed rising or with key_data changing while is_pressed stays 1 (direct key-to-key transition).
REQ-021 Recommitting an unchanged state SHALL NOT pulse key_pulse or toggle any output.
REQ-022 With DEBOUNCE_SWEEPS=1, every sweep result SHALL commit on the clock after its EVAL.
REQ-023 Bounce shorter than DEBOUNCE_SWEEPS sweeps SHALL produce no output change.

Reset
REQ-024 On sys_rst_n low, the block SHALL immediately and asynchronously set: col_n=4'b1110, is_pressed=0, key_data=4'h0, key_pulse=0, state SCAN, column 0, divider 0, synchronizer flops 4'b1111, candidate none, match counter 0.
REQ-025 Reset asserted mid-sweep or mid-press SHALL discard all partial results. After release, the first commit SHALL occur no earlier than DEBOUNCE_SWEEPS full sweeps later.

Verification (SCAN_DIV=4, DEBOUNCE_SWEEPS=3, sweep = 17 clocks)
REQ-026 Reset release, no key -> col_n cycles 1110,1101,1011,0111 every 4 clocks, then 1111 for 1 clock; is_pressed stays 0 and key_pulse never fires.
REQ-027 Key r1/c1 held (row_n[1] low while col_n[1] low) -> after the 3rd matching sweep: is_pressed=1, key_data=4'h5, key_pulse high for 1 clock. On release, is_pressed=0 after 3 sweeps; key_data stays 5.
REQ-028 Key r3/c3 held for 2 sweeps then released -> no output change (bounce rejected).
REQ-029 Keys r0/c0 and r2/c1 held together -> treated as none; is_pressed=0.
REQ-030 Key r0/c3 (A) committed, then switched directly to r0/c0 (1) -> key_data goes A->1 with a second key_pulse; is_pressed stays 1 throughout.
REQ-031 sys_rst_n pulsed low while key 7 is committed -> outputs return to reset values within the same cycle. With the key still held, recommit to key_data=7 happens exactly 3 sweeps after release.
